// File: rtl/apb_interconnect.sv
// APB 1-to-N interconnect: decodes upstream address into fixed 2^REGION_BITS windows and
// replays the transfer downstream. Optional ACCESS timeout is built when APB_IC_TIMEOUT_EN is defined.
module apb_interconnect #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SLAVE   = 4,
    parameter int REGION_BITS = 12,
    parameter int TIMEOUT     = 16
) (
    input  logic                                  S_PCLK,
    input  logic                                  S_PRESET,
    input  logic [ADDR_WIDTH-1:0]                 S_PADDR,
    input  logic                                  S_PSEL,
    input  logic                                  S_PENABLE,
    input  logic                                  S_PWRITE,
    input  logic [DATA_WIDTH-1:0]                 S_PWDATA,
    output logic                                  S_PREADY,
    output logic [DATA_WIDTH-1:0]                 S_PRDATA,
    output logic                                  S_PSLVERR,
    output logic [ADDR_WIDTH-1:0]                 M_PADDR,
    output logic                                  M_PWRITE,
    output logic [DATA_WIDTH-1:0]                 M_PWDATA,
    output logic                                  M_PENABLE,
    output logic [NUM_SLAVE-1:0]                  M_PSEL,
    input  logic [NUM_SLAVE-1:0]                  M_PREADY,
    input  logic [NUM_SLAVE-1:0][DATA_WIDTH-1:0]  M_PRDATA,
    input  logic [NUM_SLAVE-1:0]                  M_PSLVERR
);
    localparam int IDX_W = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

    state_t                 state, state_n;
    logic [IDX_W-1:0]       idx_q, idx_n;
    logic                   drop_q, drop_n;
    logic [ADDR_WIDTH-1:0]  addr_n, dec_idx;
    logic                   write_n;
    logic [DATA_WIDTH-1:0]  wdata_n, rdata_n;
    logic                   err_n;
    logic                   hit, ready_sel, tmo_hit, resp_vis;
    logic [NUM_SLAVE-1:0]   psel_n;

`ifdef APB_IC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Cleared while in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge S_PCLK) begin
        if (S_PRESET || state == SETUP)
            tmo_cnt <= '0;
        else if (state == ACCESS && !ready_sel)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign dec_idx   = S_PADDR >> REGION_BITS;
    assign hit       = (dec_idx < ADDR_WIDTH'(NUM_SLAVE));
    assign ready_sel = M_PREADY[idx_q];

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        drop_n  = drop_q;
        addr_n  = M_PADDR;
        write_n = M_PWRITE;
        wdata_n = M_PWDATA;
        rdata_n = '0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (S_PSEL && !S_PENABLE) begin
                    drop_n = 1'b0;
                    if (hit) begin
                        state_n = SETUP;
                        idx_n   = IDX_W'(dec_idx);
                        addr_n  = S_PADDR;
                        write_n = S_PWRITE;
                        wdata_n = S_PWDATA;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            SETUP: begin
                state_n = ACCESS;
                if (!S_PSEL) drop_n = 1'b1;
            end
            ACCESS: begin
                // A master that abandons the transfer still lets the slave finish; only the reply is suppressed.
                if (!S_PSEL) drop_n = 1'b1;
                if (ready_sel) begin
                    state_n = RESP;
                    rdata_n = M_PRDATA[idx_q];
                    err_n   = M_PSLVERR[idx_q];
                end else if (tmo_hit) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        psel_n = '0;
        if (state_n == SETUP || state_n == ACCESS)
            psel_n = NUM_SLAVE'(1) << idx_n;
        resp_vis = (state_n == RESP) && !drop_n;
    end

    // All outputs are registered from next-state values so they change only on the clock edge.
    always_ff @(posedge S_PCLK) begin
        if (S_PRESET) begin
            state     <= IDLE;
            idx_q     <= '0;
            drop_q    <= 1'b0;
            M_PADDR   <= '0;
            M_PWRITE  <= 1'b0;
            M_PWDATA  <= '0;
            M_PSEL    <= '0;
            M_PENABLE <= 1'b0;
            S_PREADY  <= 1'b0;
            S_PSLVERR <= 1'b0;
            S_PRDATA  <= '0;
        end else begin
            state     <= state_n;
            idx_q     <= idx_n;
            drop_q    <= drop_n;
            M_PADDR   <= addr_n;
            M_PWRITE  <= write_n;
            M_PWDATA  <= wdata_n;
            M_PSEL    <= psel_n;
            M_PENABLE <= (state_n == ACCESS);
            S_PREADY  <= resp_vis || (state_n == ERR);
            S_PSLVERR <= (resp_vis && err_n) || (state_n == ERR);
            S_PRDATA  <= resp_vis ? rdata_n : '0;
        end
    end
endmodule

// File: tb/tb_apb_interconnect.sv
// Scoreboard bench for apb_interconnect (default parameters); covers the timeout path when APB_IC_TIMEOUT_EN is defined.
module tb_apb_interconnect;
    logic              clk = 1'b0;
    logic              S_PRESET;
    logic [31:0]       S_PADDR;
    logic              S_PSEL, S_PENABLE, S_PWRITE;
    logic [31:0]       S_PWDATA;
    logic              S_PREADY, S_PSLVERR;
    logic [31:0]       S_PRDATA;
    logic [31:0]       M_PADDR, M_PWDATA;
    logic              M_PWRITE, M_PENABLE;
    logic [3:0]        M_PSEL, M_PREADY, M_PSLVERR;
    logic [3:0][31:0]  M_PRDATA;

    apb_interconnect dut (
        .S_PCLK(clk), .S_PRESET(S_PRESET), .S_PADDR(S_PADDR), .S_PSEL(S_PSEL),
        .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE), .S_PWDATA(S_PWDATA),
        .S_PREADY(S_PREADY), .S_PRDATA(S_PRDATA), .S_PSLVERR(S_PSLVERR),
        .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA),
        .M_PENABLE(M_PENABLE), .M_PSEL(M_PSEL), .M_PREADY(M_PREADY),
        .M_PRDATA(M_PRDATA), .M_PSLVERR(M_PSLVERR)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rd; logic err; int at; } resp_t;
    typedef struct { logic [3:0] psel; logic [31:0] addr; logic [31:0] wdata; logic write; } down_t;
    resp_t sb_q[$];
    down_t dq[$];

    // Slave models: ready after wait_cfg[i] ACCESS cycles.
    int          wait_cfg[4];
    int          wcnt[4];
    logic [31:0] rdata_cfg[4];
    logic        err_cfg[4];

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (!M_PENABLE) wcnt[i] <= 0;
            else if (M_PSEL[i] && !M_PREADY[i]) wcnt[i] <= wcnt[i] + 1;

    always_comb begin
        M_PREADY  = '0;
        M_PSLVERR = '0;
        M_PRDATA  = '0;
        for (int i = 0; i < 4; i++) begin
            M_PREADY[i]  = M_PSEL[i] && M_PENABLE && (wcnt[i] >= wait_cfg[i]);
            M_PSLVERR[i] = err_cfg[i];
            M_PRDATA[i]  = rdata_cfg[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream response monitor
    always @(negedge clk) begin
        if (S_PREADY) begin
            if (sb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pready: got S_PREADY=1 expected 0 (t=%0t)", $time);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                check("s_prdata", S_PRDATA, e.rd);
                check("s_pslverr", S_PSLVERR, e.err);
                check("latency", cyc, e.at);
            end
        end
    end

    // Downstream monitor: request must match and stay stable on every ACCESS cycle.
    always @(negedge clk) begin
        if (M_PENABLE && dq.size() > 0) begin
            down_t d;
            d = dq[0];
            check("m_psel", M_PSEL, d.psel);
            check("m_paddr", M_PADDR, d.addr);
            check("m_pwdata", M_PWDATA, d.wdata);
            check("m_pwrite", M_PWRITE, d.write);
            if ((M_PSEL & M_PREADY) != 0) void'(dq.pop_front());
        end
    end

    task automatic setup_phase(input logic [31:0] a, input logic w, input logic [31:0] wd);
        @(posedge clk); #1;
        S_PADDR = a; S_PWRITE = w; S_PWDATA = wd; S_PSEL = 1'b1; S_PENABLE = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err, input int lat,
                        input logic [3:0] psel, input bit down, input bit scramble);
        bit seen = 0;
        setup_phase(a, w, wd);
        sb_q.push_back('{rd: rd, err: err, at: cyc + lat});
        if (down) dq.push_back('{psel: psel, addr: a, wdata: wd, write: w});
        @(posedge clk); #1;
        S_PENABLE = 1'b1;
        if (scramble) begin
            S_PADDR = 32'h0000_0004; S_PWDATA = ~wd; S_PWRITE = ~w;
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (S_PREADY) seen = 1;
        end
        check("pready_seen", seen, 1'b1);
        check("psel_in_resp", M_PSEL, 4'b0000);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        S_PSEL = 1'b0; S_PENABLE = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic set_slave(input int i, input int w, input logic [31:0] rd, input logic e);
        wait_cfg[i] = w; rdata_cfg[i] = rd; err_cfg[i] = e;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_slave(i, 0, 32'h0, 1'b0);
        S_PRESET = 1'b1; S_PADDR = 32'h1234_5678; S_PSEL = 1'b1; S_PENABLE = 1'b0;
        S_PWRITE = 1'b1; S_PWDATA = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_psel", M_PSEL, 4'b0000);
        check("rst_m_penable", M_PENABLE, 1'b0);
        check("rst_s_pready", S_PREADY, 1'b0);
        check("rst_s_pslverr", S_PSLVERR, 1'b0);
        check("rst_s_prdata", S_PRDATA, 32'h0);
        check("rst_m_paddr", M_PADDR, 32'h0);
        check("rst_m_pwdata", M_PWDATA, 32'h0);
        check("rst_m_pwrite", M_PWRITE, 1'b0);
        S_PSEL = 1'b0; S_PRESET = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-wait write to slave 1
        set_slave(1, 0, 32'h0000_0000, 1'b0);
        xfer(32'h1004, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 4'b0010, 1, 0);
        // Read at top of slave 3 with two wait states
        set_slave(3, 2, 32'h1234_5678, 1'b0);
        xfer(32'h3FFC, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 5, 4'b1000, 1, 0);
        // Slave error passes through with its data, then back-to-back decode error
        set_slave(2, 0, 32'hA5A5_A5A5, 1'b1);
        xfer(32'h2010, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b1, 3, 4'b0100, 1, 0);
        xfer(32'h4000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 0, 0);
        // Last byte of the map, upstream scrambled during ACCESS
        set_slave(3, 1, 32'h0000_0077, 1'b0);
        xfer(32'h3FFF, 1'b1, 32'h0F0F_0F0F, 32'h0000_0077, 1'b0, 4, 4'b1000, 1, 1);
        xfer(32'hFFFF_FFF0, 1'b1, 32'h1, 32'h0, 1'b1, 1, 4'b0000, 0, 0);
        idle(2);

        // Master drops PSEL during SETUP: downstream completes, no upstream reply
        set_slave(1, 1, 32'h9999_9999, 1'b0);
        setup_phase(32'h1008, 1'b1, 32'h1111_2222);
        dq.push_back('{psel: 4'b0010, addr: 32'h1008, wdata: 32'h1111_2222, write: 1'b1});
        @(posedge clk); #1;
        S_PSEL = 1'b0;
        repeat (8) @(posedge clk);
        check("drop_down_done", dq.size(), 0);

        // Reset in the middle of ACCESS to slave 2
        set_slave(2, 10, 32'hCAFE_0002, 1'b0);
        setup_phase(32'h2000, 1'b0, 32'h0);
        @(posedge clk); #1; S_PENABLE = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_in_access", M_PENABLE, 1'b1);
        S_PRESET = 1'b1; S_PSEL = 1'b0; S_PENABLE = 1'b0;
        @(posedge clk); #1;
        check("abort_m_psel", M_PSEL, 4'b0000);
        check("abort_m_penable", M_PENABLE, 1'b0);
        S_PRESET = 1'b0;
        set_slave(0, 0, 32'h0BAD_F00D, 1'b0);
        xfer(32'h0000, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 4'b0001, 1, 0);

        // Slave 0 never ready
        set_slave(0, 1000, 32'h5555_5555, 1'b0);
`ifdef APB_IC_TIMEOUT_EN
        xfer(32'h0010, 1'b0, 32'h0, 32'h0, 1'b1, 18, 4'b0001, 0, 0);
`else
        setup_phase(32'h0010, 1'b0, 32'h0);
        @(posedge clk); #1; S_PENABLE = 1'b1;
        repeat (30) @(negedge clk);
        check("wait_m_penable", M_PENABLE, 1'b1);
        check("wait_m_psel", M_PSEL, 4'b0001);
        check("wait_s_pready", S_PREADY, 1'b0);
        @(posedge clk); #1;
        S_PRESET = 1'b1; S_PSEL = 1'b0; S_PENABLE = 1'b0;
        @(posedge clk); #1;
        S_PRESET = 1'b0;
`endif
        idle(4);
        check("sb_empty", sb_q.size(), 0);
        check("down_empty", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_interconnect.md
APB_INTERCONNECT -- requirements
Module: apb_interconnect

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the read and write data buses.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter NUM_SLAVE, default 4: number of downstream slaves (1..16).
REQ-004 Parameter REGION_BITS, default 12: each slave window is 2^REGION_BITS bytes; slave i spans [i<<REGION_BITS, ((i+1)<<REGION_BITS)-1].
REQ-005 Parameter TIMEOUT, default 16: maximum number of ACCESS cycles before a forced error (>=2).
REQ-006 S_PCLK  in  1  single clock; all logic is on its rising edge.
REQ-007 S_PRESET  in  1  reset; synchronous, active-high.
REQ-008 S_PADDR  in  ADDR_WIDTH, S_PSEL  in  1, S_PENABLE  in  1, S_PWRITE  in  1, S_PWDATA  in  DATA_WIDTH  upstream APB request.
REQ-009 S_PREADY  out  1, S_PRDATA  out  DATA_WIDTH, S_PSLVERR  out  1  upstream APB response.
REQ-010 M_PADDR  out  ADDR_WIDTH, M_PWRITE  out  1, M_PWDATA  out  DATA_WIDTH, M_PENABLE  out  1  registered downstream request, shared by all slaves.
REQ-011 M_PSEL  out  NUM_SLAVE  one-hot registered slave select.
REQ-012 M_PREADY  in  NUM_SLAVE, M_PRDATA  in  NUM_SLAVE x DATA_WIDTH, M_PSLVERR  in  NUM_SLAVE  per-slave responses.

Function
REQ-013 FSM states: IDLE, SETUP, ACCESS, RESP, ERR.
REQ-014 IDLE: on S_PSEL=1 and S_PENABLE=0, decode idx=S_PADDR>>REGION_BITS; if idx<NUM_SLAVE, latch addr/write/wdata/idx and go to SETUP; otherwise go to ERR.
REQ-015 SETUP: M_PSEL[idx]=1, M_PENABLE=0; next state is ACCESS unconditionally.
REQ-016 ACCESS: M_PSEL[idx]=1, M_PENABLE=1; when M_PREADY[idx]=1, capture M_PRDATA[idx] and M_PSLVERR[idx] and go to RESP.
REQ-017 RESP: S_PREADY=1 for exactly one cycle, with the captured data and error; next state is IDLE.
REQ-018 ERR: S_PREADY=1, S_PSLVERR=1, S_PRDATA=0 for one cycle; no M_PSEL bit is asserted; next state is IDLE.
REQ-019 Outside RESP and ERR: S_PREADY=0, S_PSLVERR=0, S_PRDATA=0.
REQ-020 Latency with a zero-wait slave: S_PREADY asserts 3 cycles after the upstream setup cycle; each downstream wait state adds 1 cycle.
REQ-021 M_PSEL is zero or one-hot at all times; M_PADDR, M_PWRITE and M_PWDATA are held stable from SETUP through the end of ACCESS.
REQ-022 The request is sampled only in IDLE; upstream changes during SETUP, ACCESS or RESP are ignored.
REQ-023 If S_PSEL drops mid-transfer, the downstream transfer still completes and its response is discarded.
REQ-024 A new setup phase present in the cycle after RESP or ERR is accepted with no idle gap.
REQ-025 Address at the exact top of the map (NUM_SLAVE<<REGION_BITS) takes the ERR path; address (NUM_SLAVE<<REGION_BITS)-1 selects slave NUM_SLAVE-1.

Reset
REQ-026 While S_PRESET=1 at a clock edge: state=IDLE; all M_PSEL bits, M_PENABLE, S_PREADY and S_PSLVERR are 0; M_PADDR, M_PWDATA, M_PWRITE and S_PRDATA are 0; the timeout counter is 0.
REQ-027 Reset asserted mid-transfer aborts the transfer in the same edge; no response is issued for it.

Configuration
REQ-028 Macro APB_IC_TIMEOUT_EN: when defined, a counter clears on entry to ACCESS and increments each ACCESS cycle with M_PREADY[idx]=0.
REQ-029 With APB_IC_TIMEOUT_EN defined: on the TIMEOUT-th ACCESS cycle without ready, M_PSEL and M_PENABLE deassert next edge and the block enters RESP with S_PSLVERR=1 and S_PRDATA=0.
REQ-030 Without APB_IC_TIMEOUT_EN: no counter is built and ACCESS waits indefinitely for M_PREADY[idx].

Verification
REQ-031 Write of 0xDEADBEEF to 0x1004 with slave 1 at zero wait -> M_PSEL=0b0010, M_PADDR=0x1004, M_PWDATA=0xDEADBEEF; S_PREADY=1 three cycles after setup with S_PSLVERR=0.
REQ-032 Read of 0x3FFC with slave 3 returning 0x12345678 after 2 wait states -> S_PRDATA=0x12345678 with S_PREADY five cycles after setup.
REQ-033 Access to 0x4000 (NUM_SLAVE=4) -> M_PSEL stays 0; next cycle S_PREADY=1, S_PSLVERR=1, S_PRDATA=0.
REQ-034 APB_IC_TIMEOUT_EN defined, TIMEOUT=16, slave 0 never ready -> after 16 ACCESS cycles M_PSEL=0; S_PREADY=1 with S_PSLVERR=1.
REQ-035 S_PRESET=1 during ACCESS to slave 2 -> next edge M_PSEL=0, M_PENABLE=0, state IDLE; no S_PREADY pulse; a following access to 0x0000 completes normally.
